// File: rtl/order_pkg.sv
// order_pkg: shared state encoding and default parameter values for the
// order-entry controller and its testbench.
// Contents: state_t (3-bit FSM encoding), DEF_* defaults, is_order_state().
package order_pkg;

  // Controller states; 3-bit encoding leaves code 7 unused (recovers to IDLE).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAIN    = 3'd1,
    ST_SIDE    = 3'd2,
    ST_DRINK   = 3'd3,
    ST_SIZE    = 3'd4,
    ST_CONFIRM = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Default build-time values for the top-level parameters.
  localparam int DEF_OPT_W      = 2;
  localparam int DEF_PRICE_W    = 8;
  localparam int DEF_BASE_PRICE = 5;
  localparam int DEF_SIZE_STEP  = 3;
  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_CNT_W      = 8;

  // True for the states in which the inactivity timer runs (MAIN..CONFIRM).
  function automatic logic is_order_state(input state_t st);
    return (st != ST_IDLE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: registers one push-button and flags its rising edge.
// Latency: o_edge is combinational from i_btn; the history register updates every clock.
// Backpressure: none; a held button produces exactly one edge.
// Ports: i_clk, i_reset (async, active-high), i_btn (raw button), o_edge (first-high cycle).
module btn_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_edge
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_btn;
    end
  end

  assign o_edge = i_btn & ~r_q;

endmodule

// File: rtl/order_menu_fsm_p.sv
// order_menu_fsm_p: restaurant order-entry controller (main/side/drink/size, price, confirm).
// Latency: state and registered outputs change on the clock edge where a button is first seen high.
// Backpressure: none; button events outside their accepting state are dropped.
// Ports: i_clk, i_reset (async, active-high); i_pb_start/i_pb_ok/i_pb_cancel buttons,
//        i_opt option code; o_main_sel/o_side_sel/o_drink_sel/o_size_sel latched fields,
//        o_price, o_busy, o_order_valid/o_cancelled/o_timeout pulses, o_order_cnt.
module order_menu_fsm_p
  import order_pkg::*;
#(
  parameter int OPT_W      = DEF_OPT_W,
  parameter int PRICE_W    = DEF_PRICE_W,
  parameter int BASE_PRICE = DEF_BASE_PRICE,
  parameter int SIZE_STEP  = DEF_SIZE_STEP,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pb_start,
  input  logic               i_pb_ok,
  input  logic               i_pb_cancel,
  input  logic [OPT_W-1:0]   i_opt,
  output logic [OPT_W-1:0]   o_main_sel,
  output logic [OPT_W-1:0]   o_side_sel,
  output logic [OPT_W-1:0]   o_drink_sel,
  output logic [OPT_W-1:0]   o_size_sel,
  output logic [PRICE_W-1:0] o_price,
  output logic               o_busy,
  output logic               o_order_valid,
  output logic               o_cancelled,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_order_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int SUM_W = PRICE_W + OPT_W + 2;
  localparam logic [SUM_W-1:0] SAT_LIM = {{(SUM_W-PRICE_W){1'b0}}, {PRICE_W{1'b1}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // Registered state
  state_t             r_state;
  logic [OPT_W-1:0]   r_main, r_side, r_drink, r_size;
  logic [PRICE_W-1:0] r_price;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic               r_valid, r_canc, r_to;

  // Next-state values
  state_t             w_nxt_state;
  logic [OPT_W-1:0]   w_nxt_main, w_nxt_side, w_nxt_drink, w_nxt_size;
  logic [PRICE_W-1:0] w_nxt_price;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [TMR_W-1:0]   w_nxt_timer;
  logic               w_nxt_valid, w_nxt_canc, w_nxt_to;
  logic               w_do_cancel;

  // Button edges and prioritised events
  logic w_e_start, w_e_ok, w_e_cancel;
  logic w_start_ev, w_ok_ev, w_cancel_ev;
  logic w_tmr_exp;

  // Price datapath
  logic [SUM_W-1:0]   w_sum;
  logic [PRICE_W-1:0] w_price_new;

  btn_edge u_edge_start  (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_pb_start),  .o_edge(w_e_start));
  btn_edge u_edge_ok     (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_pb_ok),     .o_edge(w_e_ok));
  btn_edge u_edge_cancel (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_pb_cancel), .o_edge(w_e_cancel));

  // cancel > ok > start: a lower-priority edge in the same cycle is discarded,
  // even when the winning event is itself ignored by the current state.
  assign w_cancel_ev = w_e_cancel;
  assign w_ok_ev     = w_e_ok & ~w_e_cancel;
  assign w_start_ev  = w_e_start & ~w_e_ok & ~w_e_cancel;

  assign w_tmr_exp = (r_timer == TMR_LAST);

  // Price uses the size code being accepted this cycle (i_opt), since the
  // size field itself only updates on the same edge the price is captured.
  always_comb begin
    w_sum = SUM_W'(BASE_PRICE) + SUM_W'(r_main) + SUM_W'(r_side) + SUM_W'(r_drink)
          + SUM_W'(i_opt) * SUM_W'(SIZE_STEP);
    if (w_sum > SAT_LIM) begin
      w_price_new = {PRICE_W{1'b1}};
    end else begin
      w_price_new = w_sum[PRICE_W-1:0];
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_main  = r_main;
    w_nxt_side  = r_side;
    w_nxt_drink = r_drink;
    w_nxt_size  = r_size;
    w_nxt_price = r_price;
    w_nxt_cnt   = r_cnt;
    w_nxt_valid = 1'b0;
    w_nxt_canc  = 1'b0;
    w_nxt_to    = 1'b0;
    w_do_cancel = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_ev) begin
          w_nxt_state = ST_MAIN;
        end
      end

      ST_MAIN, ST_SIDE, ST_DRINK, ST_SIZE: begin
        if (w_cancel_ev) begin
          w_do_cancel = 1'b1;
        end else if (w_ok_ev) begin
          case (r_state)
            ST_MAIN: begin
              w_nxt_main  = i_opt;
              w_nxt_state = ST_SIDE;
            end
            ST_SIDE: begin
              w_nxt_side  = i_opt;
              w_nxt_state = ST_DRINK;
            end
            ST_DRINK: begin
              w_nxt_drink = i_opt;
              w_nxt_state = ST_SIZE;
            end
            default: begin
              w_nxt_size  = i_opt;
              w_nxt_price = w_price_new;
              w_nxt_state = ST_CONFIRM;
            end
          endcase
        end else if (w_tmr_exp) begin
          w_do_cancel = 1'b1;
          w_nxt_to    = 1'b1;
        end
      end

      ST_CONFIRM: begin
        if (w_cancel_ev) begin
          w_do_cancel = 1'b1;
        end else if (w_ok_ev) begin
          w_nxt_state = ST_DONE;
          w_nxt_valid = 1'b1;
          w_nxt_cnt   = r_cnt + CNT_W'(1);
        end else if (w_start_ev) begin
          // Edit: fields keep their values until re-accepted.
          w_nxt_state = ST_MAIN;
        end else if (w_tmr_exp) begin
          w_do_cancel = 1'b1;
          w_nxt_to    = 1'b1;
        end
      end

      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (w_do_cancel) begin
      w_nxt_state = ST_IDLE;
      w_nxt_main  = '0;
      w_nxt_side  = '0;
      w_nxt_drink = '0;
      w_nxt_size  = '0;
      w_nxt_price = '0;
      w_nxt_canc  = 1'b1;
    end

    // Every accepted event changes state, so a state change is the reload condition.
    if (is_order_state(r_state) && (w_nxt_state == r_state)) begin
      w_nxt_timer = r_timer + TMR_W'(1);
    end else begin
      w_nxt_timer = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_main  <= '0;
      r_side  <= '0;
      r_drink <= '0;
      r_size  <= '0;
      r_price <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_canc  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_main  <= w_nxt_main;
      r_side  <= w_nxt_side;
      r_drink <= w_nxt_drink;
      r_size  <= w_nxt_size;
      r_price <= w_nxt_price;
      r_cnt   <= w_nxt_cnt;
      r_timer <= w_nxt_timer;
      r_valid <= w_nxt_valid;
      r_canc  <= w_nxt_canc;
      r_to    <= w_nxt_to;
    end
  end

  assign o_main_sel    = r_main;
  assign o_side_sel    = r_side;
  assign o_drink_sel   = r_drink;
  assign o_size_sel    = r_size;
  assign o_price       = r_price;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_order_valid = r_valid;
  assign o_cancelled   = r_canc;
  assign o_timeout     = r_to;
  assign o_order_cnt   = r_cnt;

endmodule

// File: tb/tb_order_menu_fsm_p.sv
module tb_order_menu_fsm_p;

  localparam int T_BASE = 5;
  localparam int T_STEP = 3;
  localparam int T_TO   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       pb_start, pb_ok, pb_cancel;
  logic [1:0] opt;

  logic [1:0] d_main, d_side, d_drink, d_size;
  logic [7:0] d_price, d_cnt;
  logic       d_busy, d_valid, d_canc, d_to;

  logic [1:0] s_main, s_side, s_drink, s_size;
  logic [3:0] s_price;
  logic [7:0] s_cnt;
  logic       s_busy, s_valid, s_canc, s_to;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  order_menu_fsm_p u_dut (
    .i_clk(clk), .i_reset(reset), .i_pb_start(pb_start), .i_pb_ok(pb_ok),
    .i_pb_cancel(pb_cancel), .i_opt(opt),
    .o_main_sel(d_main), .o_side_sel(d_side), .o_drink_sel(d_drink), .o_size_sel(d_size),
    .o_price(d_price), .o_busy(d_busy), .o_order_valid(d_valid), .o_cancelled(d_canc),
    .o_timeout(d_to), .o_order_cnt(d_cnt)
  );

  order_menu_fsm_p #(.PRICE_W(4)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_pb_start(pb_start), .i_pb_ok(pb_ok),
    .i_pb_cancel(pb_cancel), .i_opt(opt),
    .o_main_sel(s_main), .o_side_sel(s_side), .o_drink_sel(s_drink), .o_size_sel(s_size),
    .o_price(s_price), .o_busy(s_busy), .o_order_valid(s_valid), .o_cancelled(s_canc),
    .o_timeout(s_to), .o_order_cnt(s_cnt)
  );

  // ---------------- reference model ----------------
  // stage: 0 idle, 1..4 choosing field (stage-1), 5 confirm, 6 done
  int m_stage, m_idle, m_cnt, m_sum;
  int m_f[4];
  int m_valid, m_canc, m_to;
  bit m_ps, m_po, m_pc;

  task automatic model_reset();
    m_stage = 0; m_idle = 0; m_cnt = 0; m_sum = 0;
    for (int k = 0; k < 4; k++) m_f[k] = 0;
    m_valid = 0; m_canc = 0; m_to = 0;
    m_ps = 0; m_po = 0; m_pc = 0;
  endtask

  task automatic model_cancel(input int is_to);
    m_stage = 0;
    for (int k = 0; k < 4; k++) m_f[k] = 0;
    m_sum  = 0;
    m_canc = 1;
    m_to   = is_to;
  endtask

  task automatic model_step(input bit s, input bit o, input bit c, input int op);
    bit es, eo, ec;
    int ev; // 0 none, 1 start, 2 ok, 3 cancel
    es = s & ~m_ps; eo = o & ~m_po; ec = c & ~m_pc;
    m_ps = s; m_po = o; m_pc = c;
    ev = ec ? 3 : eo ? 2 : es ? 1 : 0;
    m_valid = 0; m_canc = 0; m_to = 0;
    if (m_stage == 0) begin
      if (ev == 1) begin m_stage = 1; m_idle = 0; end
    end else if (m_stage == 6) begin
      m_stage = 0;
    end else if (ev == 3) begin
      model_cancel(0);
    end else if (ev == 2) begin
      m_idle = 0;
      if (m_stage == 5) begin
        m_stage = 6; m_valid = 1; m_cnt = m_cnt + 1;
      end else begin
        m_f[m_stage-1] = op;
        if (m_stage == 4) m_sum = T_BASE + m_f[0] + m_f[1] + m_f[2] + m_f[3] * T_STEP;
        m_stage = m_stage + 1;
      end
    end else if (ev == 1 && m_stage == 5) begin
      m_stage = 1; m_idle = 0;
    end else if (m_idle == T_TO - 1) begin
      model_cancel(1);
    end else begin
      m_idle = m_idle + 1;
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("busy",   32'(d_busy),  (m_stage != 0) ? 1 : 0);
    check("main",   32'(d_main),  m_f[0]);
    check("side",   32'(d_side),  m_f[1]);
    check("drink",  32'(d_drink), m_f[2]);
    check("size",   32'(d_size),  m_f[3]);
    check("price",  32'(d_price), sat(m_sum, 255));
    check("valid",  32'(d_valid), m_valid);
    check("canc",   32'(d_canc),  m_canc);
    check("tmo",    32'(d_to),    m_to);
    check("cnt",    32'(d_cnt),   m_cnt % 256);
    check("sat_price", 32'(s_price), sat(m_sum, 15));
    check("sat_busy",  32'(s_busy),  (m_stage != 0) ? 1 : 0);
  endtask

  // Drive at negedge, let one rising edge pass, advance model, compare at negedge.
  task automatic step(input bit s, input bit o, input bit c, input int op);
    pb_start = s; pb_ok = o; pb_cancel = c; opt = 2'(op);
    @(posedge clk);
    model_step(s, o, c, op);
    @(negedge clk);
    compare_all();
  endtask

  task automatic rel();
    step(0, 0, 0, 0);
  endtask

  task automatic press_ok(input int op);
    step(0, 1, 0, op);
    rel();
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic s, o, c;
    logic [1:0] opt;
    logic busy, valid, canc;
    logic [1:0] mn, sd, dr, sz;
    logic [7:0] price, cnt;
  } vec_t;

  function automatic vec_t mk(input int s, o, c, op, busy, valid, canc,
                              mn, sd, dr, sz, pr, cn);
    vec_t v;
    v.s = s[0]; v.o = o[0]; v.c = c[0]; v.opt = 2'(op);
    v.busy = busy[0]; v.valid = valid[0]; v.canc = canc[0];
    v.mn = 2'(mn); v.sd = 2'(sd); v.dr = 2'(dr); v.sz = 2'(sz);
    v.price = 8'(pr); v.cnt = 8'(cn);
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    // Full order: main=1 side=2 drink=1 size=2 -> 5+1+2+1+2*3 = 15
    tbl[0]  = mk(1,0,0,0, 1,0,0, 0,0,0,0,  0,0);
    tbl[1]  = mk(0,0,0,0, 1,0,0, 0,0,0,0,  0,0);
    tbl[2]  = mk(0,1,0,1, 1,0,0, 1,0,0,0,  0,0);
    tbl[3]  = mk(0,0,0,0, 1,0,0, 1,0,0,0,  0,0);
    tbl[4]  = mk(0,1,0,2, 1,0,0, 1,2,0,0,  0,0);
    tbl[5]  = mk(0,0,0,0, 1,0,0, 1,2,0,0,  0,0);
    tbl[6]  = mk(0,1,0,1, 1,0,0, 1,2,1,0,  0,0);
    tbl[7]  = mk(0,0,0,0, 1,0,0, 1,2,1,0,  0,0);
    tbl[8]  = mk(0,1,0,2, 1,0,0, 1,2,1,2, 15,0);
    tbl[9]  = mk(0,0,0,0, 1,0,0, 1,2,1,2, 15,0);
    tbl[10] = mk(0,1,0,0, 1,1,0, 1,2,1,2, 15,1);
    tbl[11] = mk(0,0,0,0, 0,0,0, 1,2,1,2, 15,1);
    tbl[12] = mk(0,0,1,0, 0,0,0, 1,2,1,2, 15,1);  // cancel in IDLE ignored
    tbl[13] = mk(0,0,0,0, 0,0,0, 1,2,1,2, 15,1);

    pb_start = 0; pb_ok = 0; pb_cancel = 0; opt = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check("rst_valid", 32'(s_valid), 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].s, tbl[i].o, tbl[i].c, int'(tbl[i].opt));
      check($sformatf("tbl%0d_busy", i),  32'(d_busy),  int'(tbl[i].busy));
      check($sformatf("tbl%0d_valid", i), 32'(d_valid), int'(tbl[i].valid));
      check($sformatf("tbl%0d_canc", i),  32'(d_canc),  int'(tbl[i].canc));
      check($sformatf("tbl%0d_main", i),  32'(d_main),  int'(tbl[i].mn));
      check($sformatf("tbl%0d_side", i),  32'(d_side),  int'(tbl[i].sd));
      check($sformatf("tbl%0d_drink", i), 32'(d_drink), int'(tbl[i].dr));
      check($sformatf("tbl%0d_size", i),  32'(d_size),  int'(tbl[i].sz));
      check($sformatf("tbl%0d_price", i), 32'(d_price), int'(tbl[i].price));
      check($sformatf("tbl%0d_cnt", i),   32'(d_cnt),   int'(tbl[i].cnt));
    end

    // Edit from CONFIRM, re-enter all 3s -> 5+3+3+3+9 = 23 (15 when PRICE_W=4)
    step(1, 0, 0, 0); rel();
    press_ok(1); press_ok(2); press_ok(1); press_ok(2);
    check("pre_edit_price", 32'(d_price), 15);
    step(1, 0, 0, 0);
    check("edit_busy", 32'(d_busy), 1);
    check("edit_main_held", 32'(d_main), 1);
    check("edit_price_held", 32'(d_price), 15);
    rel();
    press_ok(3); press_ok(3); press_ok(3); press_ok(3);
    check("edit_price", 32'(d_price), 23);
    check("sat_price_15", 32'(s_price), 15);
    step(0, 1, 0, 0);
    check("edit_valid", 32'(d_valid), 1);
    check("edit_cnt", 32'(d_cnt), 2);
    rel();
    check("edit_idle", 32'(d_busy), 0);

    // Cancel in DRINK
    step(1, 0, 0, 0); rel();
    press_ok(1); press_ok(2);
    step(0, 0, 1, 0);
    check("cdrink_canc", 32'(d_canc), 1);
    check("cdrink_busy", 32'(d_busy), 0);
    check("cdrink_main", 32'(d_main), 0);
    check("cdrink_price", 32'(d_price), 0);
    check("cdrink_cnt", 32'(d_cnt), 2);
    check("cdrink_tmo", 32'(d_to), 0);
    rel();
    check("cdrink_pulse_len", 32'(d_canc), 0);

    // ok + cancel together in SIDE: cancel wins
    step(1, 0, 0, 0); rel();
    press_ok(2);
    step(0, 1, 1, 3);
    check("okc_canc", 32'(d_canc), 1);
    check("okc_side", 32'(d_side), 0);
    check("okc_main", 32'(d_main), 0);
    rel();

    // Held ok in MAIN: one advance only
    step(1, 0, 0, 0); rel();
    repeat (5) step(0, 1, 0, 3);
    check("held_main", 32'(d_main), 3);
    check("held_side", 32'(d_side), 0);
    rel();
    press_ok(1);
    check("held_side_next", 32'(d_side), 1);
    check("held_drink", 32'(d_drink), 0);
    step(0, 0, 1, 0); rel();

    // Timeout: 16 cycles busy in MAIN, then pulses with IDLE
    step(1, 0, 0, 0);
    check("to_busy0", 32'(d_busy), 1);
    pb_start = 0;
    for (int k = 1; k < T_TO; k++) begin
      rel();
      check($sformatf("to_busy%0d", k), 32'(d_busy), 1);
      check($sformatf("to_nocanc%0d", k), 32'(d_canc), 0);
    end
    rel();
    check("to_canc", 32'(d_canc), 1);
    check("to_tmo", 32'(d_to), 1);
    check("to_busy", 32'(d_busy), 0);
    rel();
    check("to_pulse_len", 32'(d_to), 0);

    // Reset mid-SIZE: immediate async clear, no pulses
    step(1, 0, 0, 0); rel();
    press_ok(2); press_ok(2); press_ok(2);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(d_busy), 0);
    check("rst_main", 32'(d_main), 0);
    check("rst_drink", 32'(d_drink), 0);
    check("rst_cnt", 32'(d_cnt), 0);
    check("rst_canc", 32'(d_canc), 0);
    check("rst_tmo", 32'(d_to), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rel();

    // Randomized traffic against the model, varying button density
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = (blk % 3 == 0) ? 3 : (blk % 3 == 1) ? 6 : 40;
      for (int i = 0; i < 500; i++) begin
        bit rs, ro, rc;
        rs = ($urandom_range(dens - 1) == 0);
        ro = ($urandom_range(dens - 1) == 0);
        rc = ($urandom_range(dens * 4 - 1) == 0);
        step(rs, ro, rc, int'($urandom_range(3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
